// File: rtl/i2c_status_update_arbiter.sv
// i2c_status_update_arbiter
//
// Shares the I2C status holding register between the APB bus side (loads and
// flag clears) and the I2C core (hardware status loads). Only one operation is
// issued at a time. Each operation runs IDLE -> GRANT -> SETTLE. The SETTLE
// cycle lets the register output settle before the next arbitration.
// The core has priority. A wait counter forces the bus side to win after
// MAX_WAIT consecutive lost arbitrations.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   bus_req    APB request, held with bus_clr/bus_data until bus_gnt
//   bus_clr    1 = clear-flag operation, 0 = load operation
//   bus_data   APB load value
//   bus_gnt    one-cycle pulse, bus operation issued
//   core_req   core request (always a load), held with core_data until core_gnt
//   core_data  core load value
//   core_gnt   one-cycle pulse, core operation issued
//   reg_q      current register contents (clear pass-through source)
//   reg_data   value presented to the register
//   reg_load   register loads reg_data this cycle
//   reg_clear  register loads reg_data with bit NUM_BITS-1 forced low
//   busy       high whenever the FSM is not idle

module i2c_status_update_arbiter #(
    parameter int unsigned NUM_BITS = 8,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_clr,
    input  logic [NUM_BITS:0] bus_data,
    output logic              bus_gnt,
    input  logic              core_req,
    input  logic [NUM_BITS:0] core_data,
    output logic              core_gnt,
    input  logic [NUM_BITS:0] reg_q,
    output logic [NUM_BITS:0] reg_data,
    output logic              reg_load,
    output logic              reg_clear,
    output logic              busy
);

    localparam int unsigned     WaitW   = $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StSettle
    } state_e;

    state_e            state_q;
    logic [WaitW-1:0]  wait_cnt_q;
    logic [NUM_BITS:0] data_q;
    logic              winner_q;  // 1 = bus owns the current operation
    logic              op_q;      // 1 = clear operation, 0 = load

    logic bus_wins;
    logic in_grant;

    // Bus wins when it is alone, or when it has lost MAX_WAIT times in a row.
    always_comb begin
        bus_wins = bus_req & (~core_req | (wait_cnt_q == WaitMax));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            data_q     <= '0;
            winner_q   <= 1'b0;
            op_q       <= 1'b0;
        end else begin
            // A withdrawn bus request forfeits its accumulated waiting credit.
            if (!bus_req) begin
                wait_cnt_q <= '0;
            end

            case (state_q)
                StIdle: begin
                    if (bus_req || core_req) begin
                        state_q <= StGrant;
                        if (bus_wins) begin
                            winner_q   <= 1'b1;
                            op_q       <= bus_clr;
                            wait_cnt_q <= '0;
                            // A clear uses reg_q directly, so data_q keeps the last load.
                            if (!bus_clr) begin
                                data_q <= bus_data;
                            end
                        end else begin
                            winner_q <= 1'b0;
                            op_q     <= 1'b0;
                            data_q   <= core_data;
                            if (bus_req && (wait_cnt_q != WaitMax)) begin
                                wait_cnt_q <= wait_cnt_q + WaitW'(1);
                            end
                        end
                    end
                end
                StGrant: begin
                    state_q <= StSettle;
                end
                StSettle: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Strobes are decoded from registered state. rst masks them at once, so a
    // GRANT cycle that is cut short by reset never reaches the register.
    always_comb begin
        in_grant  = (state_q == StGrant) & ~rst;
        bus_gnt   = in_grant & winner_q;
        core_gnt  = in_grant & ~winner_q;
        reg_load  = in_grant & ~op_q;
        reg_clear = in_grant & op_q;
        reg_data  = ((state_q == StGrant) && op_q) ? reg_q : data_q;
        busy      = (state_q != StIdle);
    end

endmodule

// File: doc/i2c_status_update_arbiter.md
Name: i2c_status_update_arbiter

Overview:
Shares the I2C peripheral's (NUM_BITS+1)-bit status holding register between two requesters: the APB bus interface (software writes and flag clears) and the I2C core (hardware status updates). It arbitrates the requests and issues one load or clear operation at a time to the register. After each operation it holds a settle cycle so the register output is stable before the next operation. The I2C core has priority, and a wait counter guarantees that the bus side eventually wins.

Parameters:
NUM_BITS, 8, register MSB index; all data paths are NUM_BITS+1 bits wide ([NUM_BITS:0]); must be >= 2.
MAX_WAIT, 4, number of consecutive lost arbitrations after which the bus requester is forced to win; must be >= 1.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  reset, synchronous, active-high.
bus_req  in  1  APB-side request; held high with bus_data/bus_clr stable until bus_gnt.
bus_clr  in  1  qualifies bus_req: 1 = clear-flag operation, 0 = load operation.
bus_data  in  NUM_BITS+1  APB load value.
bus_gnt  out  1  one-cycle pulse: bus operation issued this cycle.
core_req  in  1  I2C core request; held high with core_data stable until core_gnt.
core_data  in  NUM_BITS+1  core load value.
core_gnt  out  1  one-cycle pulse: core operation issued this cycle.
reg_q  in  NUM_BITS+1  current register contents.
reg_data  out  NUM_BITS+1  value presented to the register.
reg_load  out  1  register loads reg_data at the end of this cycle.
reg_clear  out  1  register loads reg_data with bit NUM_BITS-1 forced to 0 at the end of this cycle.
busy  out  1  high whenever state != IDLE.

Behaviour:
- FSM states and transitions:
  - IDLE: when any request is present at a clock edge, go to GRANT; otherwise stay.
  - GRANT: lasts exactly 1 cycle, then go to SETTLE.
  - SETTLE: lasts exactly 1 cycle, then go to IDLE.
  - Throughput is at most one operation per 3 cycles.
- Arbitration, evaluated at the IDLE edge only:
  - Only core_req: core wins.
  - Only bus_req: bus wins.
  - Both: core wins, unless wait_cnt == MAX_WAIT, in which case bus wins.
  - The winner and its operation type are registered into internal winner and op registers.
- wait_cnt, width $clog2(MAX_WAIT+1):
  - At the IDLE edge: increments when both requests are present and core wins; saturates at MAX_WAIT.
  - Cleared when the bus wins.
  - Cleared at any edge where bus_req is low.
  - Held in GRANT and SETTLE.
- Data capture at the IDLE→GRANT edge:
  - Load operation: the winner's data is registered into a data_q register.
  - Clear operation: no capture.
- GRANT cycle outputs:
  - Load: reg_load=1, reg_clear=0, reg_data=data_q.
  - Clear (bus only, bus_clr=1): reg_clear=1, reg_load=0, reg_data=reg_q (combinational pass-through), so only bit NUM_BITS-1 changes.
  - The winner's gnt=1; the other gnt=0.
  - reg_load and reg_clear are never high together.
- The core has no clear path; core_req always means a load.
- Latency: a request first seen at IDLE edge N gives gnt and reg_load/reg_clear during cycle N+1. The register reflects the new value from cycle N+2 (SETTLE).
- A requester keeping req high after its gnt is a new request, evaluated at the next IDLE edge.
- Outside GRANT: reg_load=0, reg_clear=0, bus_gnt=0, core_gnt=0, reg_data=data_q.
- Reset (rst=1 at an edge):
  - state=IDLE, wait_cnt=0, data_q=0, winner/op cleared.
  - Outputs afterward: bus_gnt=0, core_gnt=0, reg_load=0, reg_clear=0, reg_data=0, busy=0.
- Reset mid-operation: while rst is high, gnt/reg_load/reg_clear are forced low combinationally. An in-flight operation is dropped, and the requester must still be requesting to be served after reset.
- Requests arriving during GRANT or SETTLE are ignored until the next IDLE edge; no queuing.

Test Plan:
- Reset: rst=1 for 2 cycles with both reqs high → all outputs 0, busy=0. Release → GRANT to core the next cycle.
- Single core load: core_req, core_data=9'h155 → core_gnt and reg_load one cycle later, reg_data=9'h155. busy high for 2 cycles. Next op no earlier than 3 cycles after the first.
- Bus clear: reg_q=9'h1FF, bus_req=1, bus_clr=1 → reg_clear=1, reg_data=9'h1FF, bus_gnt pulse, reg_load=0. Register becomes 9'h17F.
- Contention and starvation (MAX_WAIT=4): both reqs held continuously → core wins 4 times, bus wins the 5th. wait_cnt returns to 0 and the pattern repeats.
- bus_req dropping between attempts clears wait_cnt: after 3 core wins, drop bus_req 1 cycle, then reassert → 4 more core wins before the bus is served.
- Reset during GRANT: assert rst in the GRANT cycle of a core load → reg_load/core_gnt low that cycle. After release, the core (still requesting) is granted again with the same data.
